sync_counter_mul: RTL and testbench



---
 rtl/sync_counter_pkg.sv | 21 ++
 rtl/sync_counter_ctr.sv | 37 +++
 rtl/sync_counter_mul.sv | 71 +++++++
 tb/tb_sync_counter_mul.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sync_counter_pkg.sv
// Shared types and defaults for the sync_counter_mul constant multiplier.
// Holds the engine state encoding and the cycle-counter width helper.
package sync_counter_pkg;

  localparam int WIDTH_DEFAULT  = 4;
  localparam int FACTOR_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must hold 0..FACTOR; a zero-width counter is not legal, so floor at 1.
  function automatic int cnt_width(input int factor);
    int w;
    w = $clog2(factor + 1);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/sync_counter_ctr.sv
// Cycle counter that sequences the ACCUM additions.
// clear has priority over enable; tc flags the last ACCUM cycle (cnt == FACTOR-1).
module sync_counter_ctr
  import sync_counter_pkg::*;
#(
  parameter int FACTOR = FACTOR_DEFAULT
) (
  input  logic fast_clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = cnt_width(FACTOR);

  logic [CW-1:0] cnt;

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  // With FACTOR=0 the ACCUM state is never entered, so tc is never needed.
  always_comb begin
    tc = 1'b0;
    if (FACTOR > 0) begin
      tc = (cnt == CW'(FACTOR - 1));
    end
  end

endmodule

// File: rtl/sync_counter_mul.sv
// Free-running multicycle constant multiplier: multiply = data * FACTOR mod 2^WIDTH.
// Cycle: IDLE (sample data) -> ACCUM x FACTOR -> DONE (publish product) -> IDLE.
module sync_counter_mul
  import sync_counter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int FACTOR = FACTOR_DEFAULT
) (
  input  logic             fast_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] multiply,
  output logic             done
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic             tc;

  sync_counter_ctr #(
    .FACTOR (FACTOR)
  ) u_ctr (
    .fast_clk (fast_clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .enable   (state == ACCUM),
    .tc       (tc)
  );

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (FACTOR > 0) ? ACCUM : DONE;
      ACCUM:   if (tc) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is high for exactly the one cycle following a multiply update.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      operand  <= '0;
      acc      <= '0;
      multiply <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          operand <= data;
          acc     <= '0;
        end
        ACCUM:   acc <= acc + operand;
        DONE:    multiply <= acc;
        default: acc <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_counter_mul.sv
// Self-checking bench for sync_counter_mul: per-cycle compare against a period-based model.
// The model tracks edges since reset release and predicts products with plain arithmetic.
module tb_sync_counter_mul;

  localparam int WIDTH  = 4;
  localparam int FACTOR = 2;
  localparam int PERIOD = FACTOR + 2;

  logic             fast_clk;
  logic             rst;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] multiply;
  logic             done;

  int n_checks;
  int n_fail;

  // model state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_mul;
  logic             exp_done;
  int               edge_cnt;

  sync_counter_mul #(
    .WIDTH  (WIDTH),
    .FACTOR (FACTOR)
  ) dut (
    .fast_clk (fast_clk),
    .rst      (rst),
    .data     (data),
    .multiply (multiply),
    .done     (done)
  );

  // clock / reset
  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_mul  = '0;
    exp_done = 1'b0;
    edge_cnt = 0;
  endtask

  // One rising edge of the reference: sample every PERIOD edges, publish FACTOR+1 edges later.
  task automatic model_edge(input logic [WIDTH-1:0] d);
    int pos;
    pos      = edge_cnt % PERIOD;
    exp_done = 1'b0;
    if (pos == 0) begin
      exp_q.push_back(WIDTH'((int'(d) * FACTOR) % (1 << WIDTH)));
    end
    if (pos == FACTOR + 1) begin
      if (exp_q.size() > 0) begin
        exp_mul  = exp_q.pop_front();
        exp_done = 1'b1;
      end
    end
    edge_cnt++;
  endtask

  // driver: present d, take one edge, check outputs on the falling edge
  task automatic cycle(input logic [WIDTH-1:0] d);
    data = d;
    @(posedge fast_clk);
    model_edge(d);
    @(negedge fast_clk);
    check_eq("multiply", 32'(multiply), 32'(exp_mul));
    check_eq("done", 32'(done), 32'(exp_done));
  endtask

  // Assert reset between edges and confirm it acts without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_eq({tag, "_mul_async"}, 32'(multiply), 32'd0);
    check_eq({tag, "_done_async"}, 32'(done), 32'd0);
    repeat (2) begin
      @(posedge fast_clk);
      #1;
      check_eq({tag, "_mul_held"}, 32'(multiply), 32'd0);
      check_eq({tag, "_done_held"}, 32'(done), 32'd0);
    end
    @(negedge fast_clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    data     = '0;
    rst      = 1'b1;
    model_reset();

    // reset state before any clock edge
    #1;
    check_eq("reset_mul", 32'(multiply), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    repeat (2) @(posedge fast_clk);
    @(negedge fast_clk);
    rst = 1'b0;
    model_reset();

    // basic product and wrap-around
    repeat (8) cycle(4'd5);
    check_eq("basic_5x2", 32'(multiply), 32'd10);
    repeat (8) cycle(4'd9);
    check_eq("wrap_9x2", 32'(multiply), 32'd2);
    repeat (8) cycle(4'd15);
    check_eq("wrap_15x2", 32'(multiply), 32'd14);

    // sweep 0..15, each held one full period
    for (int v = 0; v < 16; v++) begin
      repeat (PERIOD) cycle(WIDTH'(v));
    end

    // data change during ACCUM must not disturb the product in flight
    while (edge_cnt % PERIOD != 0) cycle(4'd3);
    cycle(4'd3);
    repeat (PERIOD + 3) cycle(4'd7);
    check_eq("midchange_final", 32'(multiply), 32'd14);

    // randomized data with random hold lengths
    for (int i = 0; i < 60; i++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      repeat ($urandom_range(1, 6)) cycle(d);
    end

    // random-time async reset, then normal operation again
    async_reset("rand");
    for (int i = 0; i < 20; i++) begin
      cycle(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
    end

    // reset in the middle of ACCUM with data=6
    async_reset("pre6");
    cycle(4'd6);
    cycle(4'd6);
    async_reset("mid_accum");
    repeat (2 * PERIOD) cycle(4'd6);
    check_eq("after_reset_6x2", 32'(multiply), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
